snake_game_ctrl: RTL and testbench
==================================

# snake_game_ctrl

Game sequencer for the snake design: conditions the four raw direction buttons, arbitrates and filters direction changes, generates the move tick, and issues one move request per tick to the snake datapath over a req/ack handshake. Owns game state (idle/run/over) and score. Sits between the top-level `ui_in` buttons and the snake move/collision logic; the VGA path is untouched.

## Interface
- `MAX_COUNT`, 24'd10_000_000: move-tick period in clk cycles (≥2).
- `DEB_CYCLES`, 16'd50_000: clk cycles a synchronized button level must be stable before it is accepted (≥1).

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`  in  1 each  raw asynchronous buttons, active-high.
- `step_ack`  in  1  datapath finished the requested move; one-cycle pulse.
- `collision`  in  1  move result; sampled only with `step_ack`.
- `step_req`  out  1  move request to datapath.
- `dir`  out  2  committed direction: 00 up, 01 down, 10 left, 11 right.
- `state`  out  2  00 IDLE, 01 RUN, 10 WAIT, 11 OVER.
- `score`  out  8  completed moves since game start, saturating.

## Operation
- Each button: 2-flop synchronizer, then debouncer. Per-button counter increments while synced ≠ debounced level; debounced level flips when counter reaches DEB_CYCLES−1; counter clears whenever synced = debounced.
- Press event: one-cycle pulse on debounced rising edge.
- Arbitration of same-cycle events: up > down > left > right; only the winner is considered.
- Reversal filter: event rejected if it is the opposite of `dir` (committed, not pending). Accepted event overwrites `pending`; newest accepted event wins.
- FSM:
  - IDLE: `dir`=11, `pending`=11, `score`=0, prescaler cleared. Any press event → RUN; that event goes through the filter against `dir`=11.
  - RUN: prescaler counts 0..MAX_COUNT−1 and wraps; tick = count at MAX_COUNT−1. On tick → WAIT, `step_req`←1, `dir`←`pending` on the same edge.
  - WAIT: `step_req` held 1, `dir` stable. Prescaler keeps counting; ticks here are dropped (no queueing). On `step_ack`: `collision`=1 → OVER; else `score`←min(score+1,255) → RUN. `step_req`←0 on that edge.
  - OVER: `step_req`=0, prescaler cleared, `dir`/`score` frozen. Any press event → IDLE.
- Press events are processed in RUN and WAIT. In WAIT they update `pending` only.
- `step_ack` outside WAIT is ignored.
- `collision` without `step_ack` is ignored.

## Timing
- Reset (async assert, sync release): `state`=00, `dir`=11, `step_req`=0, `score`=0, all debounce counters/levels 0, prescaler 0.
- Raw press to event: 2 sync + DEB_CYCLES cycles, ±1 cycle for the asynchronous input edge.
- Tick to `step_req` high: 1 cycle (registered). `step_req` stays high until the edge after `step_ack`=1 is sampled.
- `step_ack` to updated `state`/`score`: 1 cycle.
- First tick after entering RUN: MAX_COUNT cycles after entry. Ticks stay periodic at MAX_COUNT; they do not rebase on ack.
- Press event coincident with tick: filter/update applied first. If accepted, that direction is committed to `dir` at the same edge as `step_req` rises.
- Async reset mid-WAIT: `step_req` drops immediately. Datapath must tolerate an abandoned request.

## Test plan
Use MAX_COUNT=8, DEB_CYCLES=4.
- Reset, then idle 20 cycles → `state`=00, `dir`=11, `step_req`=0, `score`=0.
- `btn_up` pulsed 3 cycles, then held 10 cycles → short pulse yields no event. Held press → RUN within 2+4+1 cycles, `pending`=00. At first tick `step_req`=1 and `dir`=00. Ack with `collision`=0 → `score`=1, `state`=01.
- In RUN with `dir`=11, press left → rejected: `dir` stays 11 at next step. Press up and down the same cycle → `dir`=00 at next step.
- Hold `step_ack`=0 for 3×MAX_COUNT cycles → `step_req` stays 1, `state`=10, ticks dropped. Ack arrives → exactly one `score` increment.
- Ack with `collision`=1 → `state`=11, `step_req`=0, score frozen. Press any button → IDLE, `score`=0.
- Preload score 255 and ack without collision → `score` stays 255.
- Assert `rst_n`=0 mid-WAIT → outputs reach reset values without waiting for a clk edge.

Source files
------------

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: button conditioning, direction arbitration/filtering, move-tick
// generation and the req/ack move handshake towards the snake datapath.
module snake_game_ctrl #(
    parameter logic [23:0] MAX_COUNT  = 24'd10_000_000,
    parameter logic [15:0] DEB_CYCLES = 16'd50_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       step_ack,
    input  logic       collision,
    output logic       step_req,
    output logic [1:0] dir,
    output logic [1:0] state,
    output logic [7:0] score
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StWait = 2'b10,
        StOver = 2'b11
    } state_e;

    // Bit order {up, down, left, right} so the highest set bit is the arbitration winner.
    logic [3:0]  btn_raw;
    logic [3:0]  sync1_q, sync2_q;
    logic [3:0]  deb_q, deb_d, deb_prev_q;
    logic [15:0] deb_cnt_q [4];
    logic [15:0] deb_cnt_d [4];
    logic [3:0]  press;

    state_e      state_q, state_d;
    logic [1:0]  dir_q, dir_d;
    logic [1:0]  pend_q, pend_d;
    logic [7:0]  score_q, score_d;
    logic [23:0] presc_q, presc_d;

    logic        any_ev;
    logic [1:0]  win_dir;
    logic        accept;
    logic        tick;

    assign btn_raw = {btn_up, btn_down, btn_left, btn_right};
    assign press   = deb_q & ~deb_prev_q;

    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 4; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DEB_CYCLES - 16'd1) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        any_ev = |press;
        if (press[3]) begin
            win_dir = 2'b00;
        end else if (press[2]) begin
            win_dir = 2'b01;
        end else if (press[1]) begin
            win_dir = 2'b10;
        end else begin
            win_dir = 2'b11;
        end
        // Opposite direction differs only in the LSB (up/down, left/right).
        accept = any_ev && (win_dir != (dir_q ^ 2'b01));
        tick   = (presc_q == MAX_COUNT - 24'd1);
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        pend_d  = pend_q;
        score_d = score_q;
        presc_d = presc_q;
        unique case (state_q)
            StIdle: begin
                dir_d   = 2'b11;
                pend_d  = 2'b11;
                score_d = '0;
                presc_d = '0;
                if (any_ev) begin
                    state_d = StRun;
                    // Filtered against the idle direction (right), not the possibly stale dir_q.
                    if (win_dir != 2'b10) begin
                        pend_d = win_dir;
                    end
                end
            end
            StRun: begin
                presc_d = tick ? '0 : presc_q + 24'd1;
                if (accept) begin
                    pend_d = win_dir;
                end
                if (tick) begin
                    state_d = StWait;
                    dir_d   = pend_d;
                end
            end
            StWait: begin
                presc_d = tick ? '0 : presc_q + 24'd1;
                if (accept) begin
                    pend_d = win_dir;
                end
                if (step_ack) begin
                    if (collision) begin
                        state_d = StOver;
                    end else begin
                        state_d = StRun;
                        score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                    end
                end
            end
            StOver: begin
                presc_d = '0;
                if (any_ev) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < 4; i++) begin
                deb_cnt_q[i] <= '0;
            end
            state_q    <= StIdle;
            dir_q      <= 2'b11;
            pend_q     <= 2'b11;
            score_q    <= '0;
            presc_q    <= '0;
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            deb_cnt_q  <= deb_cnt_d;
            state_q    <= state_d;
            dir_q      <= dir_d;
            pend_q     <= pend_d;
            score_q    <= score_d;
            presc_q    <= presc_d;
        end
    end

    assign step_req = (state_q == StWait);
    assign dir      = dir_q;
    assign state    = state_q;
    assign score    = score_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Scoreboard bench for snake_game_ctrl: expected step directions and post-ack state/score are
// queued by the stimulus and checked by an independent monitor.
module tb_snake_game_ctrl;

    localparam logic [23:0] MC = 24'd8;
    localparam logic [15:0] DC = 16'd4;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       btn_up    = 1'b0;
    logic       btn_down  = 1'b0;
    logic       btn_left  = 1'b0;
    logic       btn_right = 1'b0;
    logic       step_ack  = 1'b0;
    logic       collision = 1'b0;
    logic       step_req;
    logic [1:0] dir;
    logic [1:0] state;
    logic [7:0] score;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [1:0] dir_exp_q[$];
    logic [9:0] ack_exp_q[$];

    snake_game_ctrl #(
        .MAX_COUNT (MC),
        .DEB_CYCLES(DC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_left (btn_left),
        .btn_right(btn_right),
        .step_ack (step_ack),
        .collision(collision),
        .step_req (step_req),
        .dir      (dir),
        .state    (state),
        .score    (score)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations on each new step request and one cycle after each ack.
    logic req_seen = 1'b0;
    logic ack_pend = 1'b0;
    always @(negedge clk) begin : monitor
        logic [9:0] e;
        logic [1:0] d;
        if (!rst_n) begin
            req_seen = 1'b0;
            ack_pend = 1'b0;
        end else begin
            if (ack_pend) begin
                if (ack_exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL ack_scoreboard: got unexpected ack response expected none");
                end else begin
                    e = ack_exp_q.pop_front();
                    check("state_after_ack", {30'd0, state}, {30'd0, e[9:8]});
                    check("score_after_ack", {24'd0, score}, {24'd0, e[7:0]});
                end
            end
            ack_pend = step_ack && step_req;
            if (step_req && !req_seen) begin
                if (dir_exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL step_dir_scoreboard: got unexpected step_req expected none");
                end else begin
                    d = dir_exp_q.pop_front();
                    check("step_dir", {30'd0, dir}, {30'd0, d});
                end
            end
            req_seen = step_req;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input logic [3:0] m);
        {btn_up, btn_down, btn_left, btn_right} = m;
    endtask

    task automatic press(input logic [3:0] m, input int hold);
        set_btn(m);
        cyc(hold);
        set_btn(4'b0000);
        cyc(10);
    endtask

    task automatic wait_req(input string name);
        int k = 0;
        while (!step_req && k < 40) begin
            @(negedge clk);
            k++;
        end
        check(name, {31'd0, step_req}, 32'd1);
    endtask

    task automatic wait_state(input logic [1:0] s, input int limit, input string name);
        int k = 0;
        while (state !== s && k < limit) begin
            @(negedge clk);
            k++;
        end
        check(name, {30'd0, state}, {30'd0, s});
    endtask

    task automatic ack(input logic c, input logic [1:0] es, input logic [7:0] esc);
        ack_exp_q.push_back({es, esc});
        @(posedge clk);
        #1;
        step_ack  = 1'b1;
        collision = c;
        @(posedge clk);
        #1;
        step_ack  = 1'b0;
        collision = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cyc(3);
        rst_n = 1'b1;
        cyc(20);
        check("reset_state", {30'd0, state}, 32'd0);
        check("reset_dir", {30'd0, dir}, 32'd3);
        check("reset_step_req", {31'd0, step_req}, 32'd0);
        check("reset_score", {24'd0, score}, 32'd0);

        // 3-cycle glitch must not survive the 4-cycle debouncer.
        btn_up = 1'b1;
        cyc(3);
        btn_up = 1'b0;
        cyc(12);
        check("short_pulse_ignored", {30'd0, state}, 32'd0);

        dir_exp_q.push_back(2'b00);
        btn_up = 1'b1;
        wait_state(2'b01, 12, "idle_to_run");
        cyc(3);
        btn_up = 1'b0;
        wait_req("req_step1");
        press(4'b0001, 10);                 // right while dir=up: accepted
        ack(1'b0, 2'b01, 8'd1);

        dir_exp_q.push_back(2'b11);
        wait_req("req_step2");
        press(4'b0010, 10);                 // left while dir=right: rejected
        ack(1'b0, 2'b01, 8'd2);

        dir_exp_q.push_back(2'b11);
        wait_req("req_step3");
        press(4'b1100, 10);                 // up+down together: up wins
        cyc(3 * 8);
        check("req_held", {31'd0, step_req}, 32'd1);
        check("wait_held", {30'd0, state}, 32'd2);
        ack(1'b0, 2'b01, 8'd3);

        dir_exp_q.push_back(2'b00);
        wait_req("req_step4");
        ack(1'b1, 2'b11, 8'd3);
        check("over_req_low", {31'd0, step_req}, 32'd0);
        cyc(20);
        check("over_state", {30'd0, state}, 32'd3);
        check("over_score_frozen", {24'd0, score}, 32'd3);
        check("over_dir_frozen", {30'd0, dir}, 32'd0);
        press(4'b0100, 10);
        check("over_to_idle", {30'd0, state}, 32'd0);
        check("idle_score_clear", {24'd0, score}, 32'd0);
        check("idle_dir", {30'd0, dir}, 32'd3);

        dir_exp_q.push_back(2'b11);
        press(4'b0001, 10);
        for (int i = 1; i <= 256; i++) begin
            wait_req("req_sat");
            ack(1'b0, 2'b01, (i > 255) ? 8'd255 : i[7:0]);
            dir_exp_q.push_back(2'b11);
        end
        check("score_saturated", {24'd0, score}, 32'd255);

        wait_req("req_before_reset");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_state", {30'd0, state}, 32'd0);
        check("async_rst_req", {31'd0, step_req}, 32'd0);
        check("async_rst_dir", {30'd0, dir}, 32'd3);
        check("async_rst_score", {24'd0, score}, 32'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        check("dir_queue_drained", dir_exp_q.size(), 32'd0);
        check("ack_queue_drained", ack_exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
        $finish;
    end

endmodule
